// File: rtl/mul_int8_arbiter.sv
// mul_int8_arbiter: shares one LAT-stage pipelined signed INT8 multiplier among NREQ requesters.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset (shared with the multiplier)
//   req_val/req_a/req_b/req_rdy      requester side; requester i uses byte i of req_a/req_b
//   mul_en0/mul_in0/mul_in1/mul_out  multiplier side; mul_out is valid LAT cycles after mul_en0
//   resp_val/resp_id/resp_data/resp_rdy  response FIFO head, tagged with the requester index
// Build option: define MUL_INT8_ARBITER_FIXED_PRIO_EN for lowest-index-wins arbitration
// instead of the default round-robin.
module mul_int8_arbiter #(
    parameter int NREQ   = 4,
    parameter int LAT    = 5,
    parameter int FDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_val,
    input  logic [8*NREQ-1:0]         req_a,
    input  logic [8*NREQ-1:0]         req_b,
    output logic [NREQ-1:0]           req_rdy,
    output logic                      mul_en0,
    output logic [7:0]                mul_in0,
    output logic [7:0]                mul_in1,
    input  logic [15:0]               mul_out,
    output logic                      resp_val,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [15:0]               resp_data,
    input  logic                      resp_rdy
);
    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(FDEPTH);
    localparam int CW  = AW + 1;

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("mul_int8_arbiter: NREQ must be in 2..8");
        end
        if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0) begin : g_bad_fdepth
            $error("mul_int8_arbiter: FDEPTH must be a power of 2 and >= 2");
        end
        if (LAT < 2) begin : g_bad_lat
            $error("mul_int8_arbiter: LAT must be >= 2");
        end
    endgenerate

    logic [IDW-1:0] g;
    logic           found;
    logic           issue;
    logic           pop;
    logic           push;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic [AW-1:0]  wp_q, wp_d;
    logic [AW-1:0]  rp_q, rp_d;
    logic [7:0]     a_q, a_d;
    logic [7:0]     b_q, b_d;
    logic [LAT-1:0] tv_q;
    logic [IDW-1:0] tid_q [LAT];
    logic [IDW-1:0] mid_q [FDEPTH];
    logic [15:0]    mdat_q [FDEPTH];

`ifdef MUL_INT8_ARBITER_FIXED_PRIO_EN
    // Scan from the top down so the lowest asserted index is the last one written.
    always_comb begin
        g     = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_val[i]) begin
                g     = IDW'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    // Scan offsets from far to near so the requester closest to the pointer wins.
    always_comb begin
        int idx;
        g     = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_val[idx]) begin
                g     = IDW'(idx);
                found = 1'b1;
            end
        end
        ptr_d = issue ? IDW'((int'(g) + 1) % NREQ) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // cnt_q counts in-flight ops plus FIFO entries, so an issue always has a FIFO slot
    // waiting for it when the product emerges from the non-stallable multiplier.
    always_comb begin
        issue    = found && !rst && (cnt_q < CW'(FDEPTH));
        req_rdy  = issue ? (NREQ'(1) << g) : '0;
        a_d      = issue ? req_a[8*int'(g) +: 8] : a_q;
        b_d      = issue ? req_b[8*int'(g) +: 8] : b_q;
        push     = tv_q[LAT-1];
        resp_val = (fcnt_q != '0);
        pop      = resp_val && resp_rdy;
        cnt_d    = cnt_q + CW'(issue) - CW'(pop);
        fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
        wp_d     = wp_q + AW'(push);
        rp_d     = rp_q + AW'(pop);
    end

    // Operands hold their last issued value when idle to avoid toggling the multiplier.
    assign mul_en0   = issue;
    assign mul_in0   = a_d;
    assign mul_in1   = b_d;
    assign resp_id   = mid_q[rp_q];
    assign resp_data = mdat_q[rp_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            fcnt_q <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tv_q   <= '0;
            for (int i = 0; i < LAT; i++) tid_q[i] <= '0;
            for (int i = 0; i < FDEPTH; i++) begin
                mid_q[i]  <= '0;
                mdat_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            a_q    <= a_d;
            b_q    <= b_d;
            tv_q   <= {tv_q[LAT-2:0], issue};
            tid_q[0] <= g;
            for (int i = 1; i < LAT; i++) tid_q[i] <= tid_q[i-1];
            if (push) begin
                mid_q[wp_q]  <= tid_q[LAT-1];
                mdat_q[wp_q] <= mul_out;
            end
        end
    end
endmodule

// File: tb/tb_mul_int8_arbiter.sv
// tb_mul_int8_arbiter: scoreboard bench for mul_int8_arbiter with a 5-stage multiplier model.
module tb_mul_int8_arbiter;
    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          cyc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_val = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_rdy;
    logic        mul_en0;
    logic [7:0]  mul_in0, mul_in1;
    logic [15:0] mul_out;
    logic        resp_val;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;
    logic        resp_rdy = 1'b1;

    logic signed [15:0] p [5];
    ent_t q[$];
    ent_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mul_int8_arbiter dut (
        .clk(clk), .rst(rst), .req_val(req_val), .req_a(req_a), .req_b(req_b),
        .req_rdy(req_rdy), .mul_en0(mul_en0), .mul_in0(mul_in0), .mul_in1(mul_in1),
        .mul_out(mul_out), .resp_val(resp_val), .resp_id(resp_id),
        .resp_data(resp_data), .resp_rdy(resp_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) p[i] <= '0;
        end else begin
            p[0] <= $signed(mul_in0) * $signed(mul_in1);
            for (int i = 1; i < 5; i++) p[i] <= p[i-1];
        end
    end
    assign mul_out = p[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_resp(input int id, input int data, input int at);
        ent_t x;
        x.id   = 2'(id);
        x.data = 16'(data);
        x.cyc  = at;
        q.push_back(x);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        chk(nm, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && resp_val && resp_rdy) begin
            if (q.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_data", 32'(resp_data), 32'(e.data));
                if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int t2a[4] = '{-128, -128, 127, 0};
    int t2b[4] = '{-128, 127, 127, -5};
    int t2p[4] = '{16384, -16256, 16129, 0};
    int t3a[4] = '{1, 4, 7, 10};
    int t3b[4] = '{-2, -3, -4, -5};
    int t3p[4] = '{-2, -12, -28, -50};
    int nis;

    initial begin
        @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy), 0);
        chk("rst_mul_en0", 32'(mul_en0), 0);
        chk("rst_resp_val", 32'(resp_val), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        step();
        rst = 1'b0;
        step();

        // single op on requester 2
        set_op(2, -7, 9);
        req_val = 4'b0100;
        @(negedge clk);
        chk("t1_req_rdy", 32'(req_rdy), 32'h4);
        chk("t1_mul_en0", 32'(mul_en0), 1);
        chk("t1_mul_in0", 32'(mul_in0), 32'hf9);
        chk("t1_mul_in1", 32'(mul_in1), 32'h09);
        expect_resp(2, -63, cyc + 6);
        step();
        req_val = 4'b0000;
        @(negedge clk);
        chk("t1_req_rdy_off", 32'(req_rdy), 0);
        drain("t1_drain");

        // corner products back-to-back on requester 0
        req_val = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_op(0, t2a[k], t2b[k]);
            @(negedge clk);
            chk("t2_req_rdy", 32'(req_rdy), 32'h1);
            expect_resp(0, t2p[k], cyc + 6);
            step();
        end
        req_val = 4'b0000;
        drain("t2_drain");

        // lone op on requester 3 (leaves the round-robin pointer at 0)
        set_op(3, 5, -6);
        req_val = 4'b1000;
        @(negedge clk);
        chk("t3pre_req_rdy", 32'(req_rdy), 32'h8);
        expect_resp(3, -30, cyc + 6);
        step();
        req_val = 4'b0000;
        drain("t3pre_drain");

`ifdef MUL_INT8_ARBITER_FIXED_PRIO_EN
        // fixed priority: requester 1 always beats requester 3
        set_op(1, 6, -7);
        set_op(3, 9, 9);
        req_val = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_req_rdy", 32'(req_rdy), 32'h2);
            expect_resp(1, -42, cyc + 6);
            step();
        end
        req_val = 4'b0000;
        drain("t6_drain");
`else
        // round-robin fairness with all requesters valid
        for (int i = 0; i < 4; i++) set_op(i, t3a[i], t3b[i]);
        req_val = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_req_rdy", 32'(req_rdy), 32'(1 << (k % 4)));
            expect_resp(k % 4, t3p[k % 4], cyc + 6);
            step();
        end
        req_val = 4'b0000;
        drain("t3_drain");
`endif

        // backpressure: credits stop issue at 8
        resp_rdy = 1'b0;
        req_val = 4'b0001;
        nis = 0;
        set_op(0, 10, 3);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("t4_req_rdy", 32'(req_rdy[0]), 32'(k < 8));
            chk("t4_mul_en0", 32'(mul_en0), 32'(k < 8));
            if (req_rdy[0]) begin
                expect_resp(0, (10 + nis) * 3, -1);
                nis++;
            end
            step();
            set_op(0, 10 + nis, 3);
        end
        chk("t4_issue_count", nis, 8);
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("t4_full_wait", 32'(req_rdy[0]), 0);
        step();
        for (int k = 0; k < 4; k++) begin
            set_op(0, 10 + nis, 3);
            @(negedge clk);
            chk("t4_resume", 32'(req_rdy[0]), 1);
            if (req_rdy[0]) begin
                expect_resp(0, (10 + nis) * 3, -1);
                nis++;
            end
            step();
        end
        req_val = 4'b0000;
        drain("t4_drain");

        // reset with 3 ops in flight and 2 in the FIFO
        resp_rdy = 1'b0;
        req_val = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            set_op(0, k + 1, 2);
            @(negedge clk);
            chk("t5_req_rdy", 32'(req_rdy), 32'h1);
            expect_resp(0, (k + 1) * 2, -1);
            step();
        end
        req_val = 4'b0000;
        step();
        step();
        chk("t5_pre_resp_val", 32'(resp_val), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_resp_val", 32'(resp_val), 0);
        q.delete();
        step();
        step();
        rst = 1'b0;
        resp_rdy = 1'b1;
        step();
        set_op(1, 3, 4);
        req_val = 4'b0010;
        @(negedge clk);
        chk("t5_req_rdy_after", 32'(req_rdy), 32'h2);
        expect_resp(1, 12, cyc + 6);
        step();
        req_val = 4'b0000;
        drain("t5_drain");
        for (int k = 0; k < 10; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
